execute_stage_mc: RTL and testbench

//  Parametrised EX stage of the 5-stage pipeline: ID/EX operands -> forwarding -> ALU/branch -> EX/MEM register.

---
 rtl/exec_pkg.sv | 45 ++++
 rtl/exec_iter_mul.sv | 86 ++++++++
 rtl/execute_stage_mc.sv | 179 +++++++++++++++++
 tb/tb_execute_stage_mc.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/exec_pkg.sv
`default_nettype none
// ============================================================================
// Module      : exec_pkg
// Description : Shared types for the EX stage (ALU ops, branch ops, forward
//               selects, multiplier states).
// Revision    : 1.0 - initial release
// ============================================================================
package exec_pkg;

    typedef enum logic [3:0] {
        ALU_ADD = 4'd0,
        ALU_SUB = 4'd1,
        ALU_AND = 4'd2,
        ALU_OR  = 4'd3,
        ALU_XOR = 4'd4,
        ALU_SLT = 4'd5,
        ALU_SLL = 4'd6,
        ALU_SRL = 4'd7,
        ALU_SRA = 4'd8,
        ALU_MUL = 4'd9
    } alu_op_e;

    typedef enum logic [1:0] {
        BR_EQ = 2'b00,
        BR_NE = 2'b01,
        BR_LT = 2'b10,
        BR_GE = 2'b11
    } br_op_e;

    // FWD_RSVD behaves exactly like FWD_RD
    typedef enum logic [1:0] {
        FWD_RD   = 2'b00,
        FWD_WB   = 2'b01,
        FWD_MEM  = 2'b10,
        FWD_RSVD = 2'b11
    } fwd_sel_e;

    typedef enum logic [1:0] {
        MUL_ST_IDLE = 2'd0,
        MUL_ST_BUSY = 2'd1,
        MUL_ST_DONE = 2'd2
    } mul_st_e;

endpackage
`default_nettype wire

// File: rtl/exec_iter_mul.sv
`default_nettype none
// ============================================================================
// Module      : exec_iter_mul
// Description : Iterative shift-add multiplier, BPC multiplier bits per cycle,
//               low XLEN product bits presented while in DONE.
// Revision    : 1.0 - initial release
// ============================================================================
module exec_iter_mul
    import exec_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int BPC  = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            flush,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] product
);

    localparam int c_N  = XLEN / BPC;
    localparam int c_CW = $clog2(c_N + 1);

    mul_st_e         r_state;
    logic [c_CW-1:0] r_cnt;
    logic [XLEN-1:0] r_a;
    logic [XLEN-1:0] r_b;
    logic [XLEN-1:0] r_acc;
    logic [XLEN-1:0] w_partial;

    always_comb begin
        w_partial = '0;
        for (int k = 0; k < BPC; k++) begin
            if (r_b[k]) begin
                w_partial = w_partial + (r_a << k);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= MUL_ST_IDLE;
            r_cnt   <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_acc   <= '0;
        end else begin
            case (r_state)
                MUL_ST_IDLE: begin
                    if (start && !flush) begin
                        r_a     <= a;
                        r_b     <= b;
                        r_acc   <= '0;
                        r_cnt   <= '0;
                        r_state <= MUL_ST_BUSY;
                    end
                end
                MUL_ST_BUSY: begin
                    if (flush) begin
                        r_state <= MUL_ST_IDLE;
                    end else begin
                        r_acc <= r_acc + w_partial;
                        r_a   <= r_a << BPC;
                        r_b   <= r_b >> BPC;
                        r_cnt <= r_cnt + c_CW'(1);
                        if (r_cnt == c_CW'(c_N - 1)) begin
                            r_state <= MUL_ST_DONE;
                        end
                    end
                end
                // The instruction leaves EX in DONE, so it never restarts here
                default: r_state <= MUL_ST_IDLE;
            endcase
        end
    end

    assign busy    = (r_state == MUL_ST_BUSY);
    assign done    = (r_state == MUL_ST_DONE);
    assign product = r_acc;

endmodule
`default_nettype wire

// File: rtl/execute_stage_mc.sv
`default_nettype none
// ============================================================================
// Module      : execute_stage_mc
// Description : Pipeline EX stage: forwarding, ALU, branch resolve, EX/MEM reg.
//               Macro EXEC_MULDIV_EN adds the iterative multiplier (stalls EX).
// Revision    : 1.0 - initial release
// ============================================================================
module execute_stage_mc
    import exec_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int MEM_AW  = 19,
    parameter int REG_AW  = 5,
    parameter int MUL_BPC = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              RegWriteE,
    input  logic              MemWriteE,
    input  logic              ResultSrcE,
    input  logic              ALUSrcE,
    input  logic              BranchE,
    input  logic              JumpE,
    input  logic [3:0]        ALUControlE,
    input  logic [1:0]        BranchOpE,
    input  logic [XLEN-1:0]   RD1_E,
    input  logic [XLEN-1:0]   RD2_E,
    input  logic [XLEN-1:0]   Imm_Ext_E,
    input  logic [XLEN-1:0]   PCE,
    input  logic [XLEN-1:0]   PCPlus4E,
    input  logic [XLEN-1:0]   ResultW,
    input  logic [REG_AW-1:0] RD_E,
    input  logic [1:0]        ForwardA_E,
    input  logic [1:0]        ForwardB_E,
    input  logic              FlushE,
    output logic              PCSrcE,
    output logic [XLEN-1:0]   PCTargetE,
    output logic              StallE,
    output logic              RegWriteM,
    output logic              MemWriteM,
    output logic              ResultSrcM,
    output logic [REG_AW-1:0] RD_M,
    output logic [XLEN-1:0]   ALU_ResultM,
    output logic [XLEN-1:0]   WriteDataM,
    output logic [XLEN-1:0]   PCPlus4M,
    output logic [MEM_AW-1:0] MemAddrM
);

    localparam int c_SHW = $clog2(XLEN);

    if ((XLEN % MUL_BPC) != 0) begin : g_bpc_check
        $error("MUL_BPC must divide XLEN");
    end

    logic [XLEN-1:0]  w_src_a;
    logic [XLEN-1:0]  w_fwd_b;
    logic [XLEN-1:0]  w_src_b;
    logic [c_SHW-1:0] w_shamt;
    logic             w_eq;
    logic             w_lt;
    logic             w_cond;
    logic [XLEN-1:0]  w_alu_result;
    logic             w_bubble;

    always_comb begin
        case (fwd_sel_e'(ForwardA_E))
            FWD_WB:  w_src_a = ResultW;
            FWD_MEM: w_src_a = ALU_ResultM;
            default: w_src_a = RD1_E;
        endcase
        case (fwd_sel_e'(ForwardB_E))
            FWD_WB:  w_fwd_b = ResultW;
            FWD_MEM: w_fwd_b = ALU_ResultM;
            default: w_fwd_b = RD2_E;
        endcase
    end

    assign w_src_b = ALUSrcE ? Imm_Ext_E : w_fwd_b;
    assign w_shamt = w_src_b[c_SHW-1:0];
    assign w_eq    = (w_src_a == w_src_b);
    assign w_lt    = ($signed(w_src_a) < $signed(w_src_b));

    always_comb begin
        case (br_op_e'(BranchOpE))
            BR_EQ:   w_cond = w_eq;
            BR_NE:   w_cond = !w_eq;
            BR_LT:   w_cond = w_lt;
            default: w_cond = !w_lt;
        endcase
    end

    assign PCSrcE    = !FlushE && (JumpE || (BranchE && w_cond));
    assign PCTargetE = PCE + Imm_Ext_E;

`ifdef EXEC_MULDIV_EN
    logic            w_mul_req;
    logic            w_mul_busy;
    logic            w_mul_done;
    logic [XLEN-1:0] w_mul_product;

    // A MUL sitting in EX only launches while the multiplier is idle
    assign w_mul_req = (alu_op_e'(ALUControlE) == ALU_MUL) && !FlushE
                       && !w_mul_busy && !w_mul_done;

    exec_iter_mul #(
        .XLEN (XLEN),
        .BPC  (MUL_BPC)
    ) u_mul (
        .clk     (clk),
        .rst     (rst),
        .start   (w_mul_req),
        .flush   (FlushE),
        .a       (w_src_a),
        .b       (w_src_b),
        .busy    (w_mul_busy),
        .done    (w_mul_done),
        .product (w_mul_product)
    );

    assign StallE = w_mul_req || w_mul_busy;
`else
    assign StallE = 1'b0;
`endif

    always_comb begin
        w_alu_result = '0;
        case (alu_op_e'(ALUControlE))
            ALU_ADD: w_alu_result = w_src_a + w_src_b;
            ALU_SUB: w_alu_result = w_src_a - w_src_b;
            ALU_AND: w_alu_result = w_src_a & w_src_b;
            ALU_OR:  w_alu_result = w_src_a | w_src_b;
            ALU_XOR: w_alu_result = w_src_a ^ w_src_b;
            ALU_SLT: w_alu_result = {{(XLEN-1){1'b0}}, w_lt};
            ALU_SLL: w_alu_result = w_src_a << w_shamt;
            ALU_SRL: w_alu_result = w_src_a >> w_shamt;
            ALU_SRA: w_alu_result = $unsigned($signed(w_src_a) >>> w_shamt);
`ifdef EXEC_MULDIV_EN
            ALU_MUL: w_alu_result = w_mul_done ? w_mul_product : '0;
`else
            ALU_MUL: w_alu_result = '0;
`endif
            default: w_alu_result = '0;
        endcase
    end

    assign w_bubble = StallE || FlushE;

    // Data fields always load; only the controls are squashed on a bubble
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            RegWriteM   <= 1'b0;
            MemWriteM   <= 1'b0;
            ResultSrcM  <= 1'b0;
            RD_M        <= '0;
            ALU_ResultM <= '0;
            WriteDataM  <= '0;
            PCPlus4M    <= '0;
        end else begin
            ALU_ResultM <= w_alu_result;
            WriteDataM  <= w_fwd_b;
            PCPlus4M    <= PCPlus4E;
            if (w_bubble) begin
                RegWriteM  <= 1'b0;
                MemWriteM  <= 1'b0;
                ResultSrcM <= 1'b0;
                RD_M       <= '0;
            end else begin
                RegWriteM  <= RegWriteE;
                MemWriteM  <= MemWriteE;
                ResultSrcM <= ResultSrcE;
                RD_M       <= RD_E;
            end
        end
    end

    assign MemAddrM = ALU_ResultM[MEM_AW-1:0];

endmodule
`default_nettype wire

// File: tb/tb_execute_stage_mc.sv
`default_nettype none
// ============================================================================
// Module      : tb_execute_stage_mc
// Description : Directed self-checking bench for execute_stage_mc (XLEN=32).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_execute_stage_mc;

    logic        clk = 1'b0;
    logic        rst;
    logic        RegWriteE, MemWriteE, ResultSrcE, ALUSrcE, BranchE, JumpE;
    logic [3:0]  ALUControlE;
    logic [1:0]  BranchOpE;
    logic [31:0] RD1_E, RD2_E, Imm_Ext_E, PCE, PCPlus4E, ResultW;
    logic [4:0]  RD_E;
    logic [1:0]  ForwardA_E, ForwardB_E;
    logic        FlushE;
    logic        PCSrcE;
    logic [31:0] PCTargetE;
    logic        StallE;
    logic        RegWriteM, MemWriteM, ResultSrcM;
    logic [4:0]  RD_M;
    logic [31:0] ALU_ResultM, WriteDataM, PCPlus4M;
    logic [18:0] MemAddrM;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    execute_stage_mc dut (
        .clk         (clk),
        .rst         (rst),
        .RegWriteE   (RegWriteE),
        .MemWriteE   (MemWriteE),
        .ResultSrcE  (ResultSrcE),
        .ALUSrcE     (ALUSrcE),
        .BranchE     (BranchE),
        .JumpE       (JumpE),
        .ALUControlE (ALUControlE),
        .BranchOpE   (BranchOpE),
        .RD1_E       (RD1_E),
        .RD2_E       (RD2_E),
        .Imm_Ext_E   (Imm_Ext_E),
        .PCE         (PCE),
        .PCPlus4E    (PCPlus4E),
        .ResultW     (ResultW),
        .RD_E        (RD_E),
        .ForwardA_E  (ForwardA_E),
        .ForwardB_E  (ForwardB_E),
        .FlushE      (FlushE),
        .PCSrcE      (PCSrcE),
        .PCTargetE   (PCTargetE),
        .StallE      (StallE),
        .RegWriteM   (RegWriteM),
        .MemWriteM   (MemWriteM),
        .ResultSrcM  (ResultSrcM),
        .RD_M        (RD_M),
        .ALU_ResultM (ALU_ResultM),
        .WriteDataM  (WriteDataM),
        .PCPlus4M    (PCPlus4M),
        .MemAddrM    (MemAddrM)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic nop();
        RegWriteE = 0; MemWriteE = 0; ResultSrcE = 0; ALUSrcE = 0;
        BranchE = 0; JumpE = 0; ALUControlE = 4'd0; BranchOpE = 2'b00;
        RD1_E = 0; RD2_E = 0; Imm_Ext_E = 0; PCE = 0; PCPlus4E = 0;
        ResultW = 0; RD_E = 0; ForwardA_E = 2'b00; ForwardB_E = 2'b00;
        FlushE = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp, input string tag);
        nop();
        ALUControlE = op; RD1_E = a; RD2_E = b; RegWriteE = 1;
        tick();
        chk(tag, ALU_ResultM, exp);
    endtask

`ifdef EXEC_MULDIV_EN
    task automatic run_mul(input logic [31:0] exp, input string tag);
        int n   = 0;
        int bad = 0;
        #1;
        while (StallE === 1'b1 && n < 200) begin
            n++;
            @(posedge clk);
            #1;
            if (RegWriteM !== 1'b0 || MemWriteM !== 1'b0 || RD_M !== 5'd0) bad++;
        end
        chk({tag, "_stall_cycles"}, n, 33);
        chk({tag, "_bubbles"}, bad, 0);
        tick();
        chk({tag, "_product"}, ALU_ResultM, exp);
        chk({tag, "_regwr"}, {31'd0, RegWriteM}, 1);
        nop();
        tick();
        chk({tag, "_one_shot"}, {31'd0, RegWriteM}, 0);
    endtask
`endif

    initial begin
        nop();
        rst = 1'b0;
        #2;
        chk("rst_regwr", {31'd0, RegWriteM}, 0);
        chk("rst_alu", ALU_ResultM, 0);
        chk("rst_rd", {27'd0, RD_M}, 0);
        chk("rst_stall", {31'd0, StallE}, 0);
        chk("rst_pc4", PCPlus4M, 0);
        tick();
        #3;
        rst = 1'b1;
        tick();

        // Forwarding: produce 7, then forward it over RD1
        nop(); RD1_E = 3; Imm_Ext_E = 4; ALUSrcE = 1; RegWriteE = 1; RD_E = 5;
        tick();
        chk("add_imm", ALU_ResultM, 7);
        chk("add_rd", {27'd0, RD_M}, 5);
        nop(); RD1_E = 5; ForwardA_E = 2'b10; Imm_Ext_E = 3; ALUSrcE = 1; RegWriteE = 1;
        tick();
        chk("fwd_mem", ALU_ResultM, 10);
        chk("fwd_mem_regwr", {31'd0, RegWriteM}, 1);
        nop(); RD1_E = 5; ForwardA_E = 2'b01; ResultW = 100; RD2_E = 30; ALUControlE = 4'd1;
        tick();
        chk("fwd_wb_sub", ALU_ResultM, 70);
        nop(); RD1_E = 8; ForwardA_E = 2'b11; Imm_Ext_E = 1; ALUSrcE = 1;
        tick();
        chk("fwd_rsvd", ALU_ResultM, 9);

        alu(4'd1, 32'd0, 32'd1, 32'hFFFF_FFFF, "sub_wrap");
        alu(4'd2, 32'hF0F0_00FF, 32'h0FF0_0F0F, 32'h00F0_000F, "and");
        alu(4'd3, 32'hF0F0_00FF, 32'h0FF0_0F0F, 32'hFFF0_0FFF, "or");
        alu(4'd4, 32'hF0F0_00FF, 32'h0FF0_0F0F, 32'hFF00_0FF0, "xor");
        alu(4'd5, 32'hFFFF_FFFF, 32'd1, 32'd1, "slt_neg");
        alu(4'd5, 32'd1, 32'hFFFF_FFFF, 32'd0, "slt_pos");
        alu(4'd6, 32'd1, 32'h24, 32'h10, "sll_mask");
        alu(4'd7, 32'h8000_0000, 32'd4, 32'h0800_0000, "srl");
        alu(4'd8, 32'h8000_0000, 32'd4, 32'hF800_0000, "sra");

        // Store: forwarded RD2 goes to WriteDataM, immediate feeds the address
        nop(); MemWriteE = 1; ALUSrcE = 1; RD1_E = 32'hFFFF_0000; Imm_Ext_E = 32'h10;
        RD2_E = 32'hDEAD; ForwardB_E = 2'b10;
        tick();
        chk("st_wdata", WriteDataM, 32'hF800_0000);
        chk("st_addr", ALU_ResultM, 32'hFFFF_0010);
        chk("st_memaddr", {13'd0, MemAddrM}, 32'h0007_0010);
        chk("st_memwr", {31'd0, MemWriteM}, 1);

        // Flush bubble and PCSrcE kill
        nop(); RegWriteE = 1; MemWriteE = 1; ResultSrcE = 1; RD_E = 7; JumpE = 1; FlushE = 1;
        #1;
        chk("flush_pcsrc", {31'd0, PCSrcE}, 0);
        tick();
        chk("flush_regwr", {31'd0, RegWriteM}, 0);
        chk("flush_memwr", {31'd0, MemWriteM}, 0);
        chk("flush_rsrc", {31'd0, ResultSrcM}, 0);
        chk("flush_rd", {27'd0, RD_M}, 0);
        nop(); ResultSrcE = 1; RegWriteE = 1; PCPlus4E = 32'h104; RD_E = 1;
        tick();
        chk("link_pc4", PCPlus4M, 32'h104);
        chk("link_rsrc", {31'd0, ResultSrcM}, 1);

        // Branch resolution (combinational)
        nop(); RD1_E = 32'hFFFF_FFFF; RD2_E = 1; BranchE = 1; BranchOpE = 2'b10;
        PCE = 32'h100; Imm_Ext_E = 32'h20;
        #1;
        chk("blt_taken", {31'd0, PCSrcE}, 1);
        chk("blt_target", PCTargetE, 32'h120);
        BranchOpE = 2'b11; #1;
        chk("bge_not", {31'd0, PCSrcE}, 0);
        RD1_E = 5; RD2_E = 5; BranchOpE = 2'b00; #1;
        chk("beq_taken", {31'd0, PCSrcE}, 1);
        BranchOpE = 2'b01; #1;
        chk("bne_not", {31'd0, PCSrcE}, 0);
        BranchE = 0; BranchOpE = 2'b00; #1;
        chk("nobranch", {31'd0, PCSrcE}, 0);
        JumpE = 1; #1;
        chk("jump", {31'd0, PCSrcE}, 1);
        PCE = 32'hFFFF_FFF0; #1;
        chk("target_wrap", PCTargetE, 32'h10);
        tick();

`ifdef EXEC_MULDIV_EN
        nop(); ALUControlE = 4'd9; RD1_E = 6; RD2_E = 7; RegWriteE = 1; RD_E = 3;
        run_mul(32'd42, "mul6x7");

        // Reset in the middle of a multiply
        nop(); ALUControlE = 4'd9; RD1_E = 6; RD2_E = 7; RegWriteE = 1; RD_E = 3;
        repeat (11) tick();
        rst = 1'b0;
        #1;
        chk("mrst_stall", {31'd0, StallE}, 0);
        chk("mrst_regwr", {31'd0, RegWriteM}, 0);
        chk("mrst_alu", ALU_ResultM, 0);
        chk("mrst_pc4", PCPlus4M, 0);
        RD1_E = 3; RD2_E = 3; RD_E = 4;
        rst = 1'b1;
        run_mul(32'd9, "mul3x3");

        // Flush during BUSY
        nop(); ALUControlE = 4'd9; RD1_E = 6; RD2_E = 7; RegWriteE = 1; RD_E = 3;
        repeat (6) tick();
        FlushE = 1;
        tick();
        nop();
        #1;
        chk("mflush_stall", {31'd0, StallE}, 0);
        chk("mflush_regwr", {31'd0, RegWriteM}, 0);
        tick();
        chk("mflush_regwr2", {31'd0, RegWriteM}, 0);
        nop(); ALUControlE = 4'd9; RD1_E = 2; RD2_E = 5; RegWriteE = 1; RD_E = 2;
        run_mul(32'd10, "mul_after_flush");
`else
        nop(); ALUControlE = 4'd9; RD1_E = 6; RD2_E = 7; RegWriteE = 1; RD_E = 3;
        #1;
        chk("nomul_stall", {31'd0, StallE}, 0);
        tick();
        chk("nomul_result", ALU_ResultM, 0);
        chk("nomul_regwr", {31'd0, RegWriteM}, 1);
        chk("nomul_stall2", {31'd0, StallE}, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
